// File: rtl/sitcpxg_tx_pkg.sv
// -----------------------------------------------------------------------------
// sitcpxg_tx_pkg
// Shared definitions for the SiTCPXG transmit arbiter: FSM state encoding,
// the burst header magic word and the maximum per-beat byte count.
// Optional feature macro used by the arbiter: SITCPXG_TX_HEADER_EN.
// -----------------------------------------------------------------------------
package sitcpxg_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [15:0] HDR_MAGIC = 16'hA55A;
  localparam logic [3:0]  MAX_BYTES = 4'd8;

  // A 64-bit beat can carry at most 8 bytes; larger counts are saturated.
  function automatic logic [3:0] clamp_bytes(input logic [3:0] b);
    return (b > MAX_BYTES) ? MAX_BYTES : b;
  endfunction

endpackage

// File: rtl/sitcpxg_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// sitcpxg_rr_pick
// Combinational round-robin picker. Searches the valid vector upward from
// ptr with wrap-around and returns the first hit.
// Ports:
//   valid  in   NUM_CH  request vector
//   ptr    in   IW      search start index
//   grant  out  NUM_CH  one-hot winner (0 when nothing valid)
//   idx    out  IW      binary index of the winner
//   any    out  1       at least one request present
// -----------------------------------------------------------------------------
module sitcpxg_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int IW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] valid,
  input  logic [IW-1:0]     ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IW-1:0]     idx,
  output logic              any
);

  always_comb begin
    int c;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = (int'(ptr) + k) % NUM_CH;
      if (!any && valid[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/sitcpxg_tx_arbiter.sv
// -----------------------------------------------------------------------------
// sitcpxg_tx_arbiter
// Shares the SiTCPXG TCP transmit port (USER_TX_D / USER_TX_B) between
// NUM_CH user streams with burst-granular round-robin arbitration.
// Optional feature macro: SITCPXG_TX_HEADER_EN -- when defined, every burst
// is preceded by one header word {A55A, channel, 00, per-channel sequence}.
//
// Ports:
//   CLK                       in   1         XGMII clock
//   RSTn                      in   1         async active-low reset
//   CH_VALID                  in   NUM_CH    per-channel beat valid
//   CH_D                      in   64*NUM_CH per-channel data, ch i at [64i+:64]
//   CH_B                      in   4*NUM_CH  per-channel byte count
//   CH_LAST                   in   NUM_CH    per-channel end of burst
//   CH_READY                  out  NUM_CH    per-channel beat accept
//   USER_SESSION_ESTABLISHED  in   1         TCP session up
//   USER_TX_AFULL             in   1         TCP core stop request
//   USER_TX_D                 out  64        data to TCP core
//   USER_TX_B                 out  4         byte count to TCP core (0 = idle)
//   GRANT                     out  NUM_CH    one-hot current owner
//   BUSY                      out  1         in HDR or DATA
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no owner; pick next requester when the session is up
// HDR   | owner chosen; emit one header word once the core can take it
// DATA  | forward the owner's beats until CH_LAST or BURST_WORDS beats
// -----------------------------------------------------------------------------
module sitcpxg_tx_arbiter
  import sitcpxg_tx_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int BURST_WORDS = 128
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [NUM_CH-1:0]    CH_VALID,
  input  logic [64*NUM_CH-1:0] CH_D,
  input  logic [4*NUM_CH-1:0]  CH_B,
  input  logic [NUM_CH-1:0]    CH_LAST,
  output logic [NUM_CH-1:0]    CH_READY,
  input  logic                 USER_SESSION_ESTABLISHED,
  input  logic                 USER_TX_AFULL,
  output logic [63:0]          USER_TX_D,
  output logic [3:0]           USER_TX_B,
  output logic [NUM_CH-1:0]    GRANT,
  output logic                 BUSY
);

  localparam int          IW       = $clog2(NUM_CH);
  localparam logic [15:0] LAST_CNT = 16'(BURST_WORDS - 1);

  state_t              state;
  logic [NUM_CH-1:0]   grant_q;
  logic [IW-1:0]       gidx;
  logic [IW-1:0]       ptr;
  logic [15:0]         beat_cnt;
  logic [63:0]         tx_d;
  logic [3:0]          tx_b;

  logic [NUM_CH-1:0]   pick_grant;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;

  logic                port_open;
  logic                sel_valid;
  logic                sel_last;
  logic [63:0]         sel_d;
  logic [3:0]          sel_b;
  logic                xfer;
  logic                burst_end;
  logic [IW-1:0]       nxt_ptr;

`ifdef SITCPXG_TX_HEADER_EN
  logic [31:0]         seq [NUM_CH];
`endif

  sitcpxg_rr_pick #(
    .NUM_CH (NUM_CH),
    .IW     (IW)
  ) u_pick (
    .valid (CH_VALID),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Core can accept a word this cycle.
  assign port_open = USER_SESSION_ESTABLISHED && !USER_TX_AFULL;

  // Ready is combinational so AFULL or session loss blocks the same cycle.
  assign CH_READY = (state == ST_DATA && port_open) ? grant_q : '0;

  assign sel_valid = CH_VALID[gidx];
  assign sel_last  = CH_LAST[gidx];
  assign sel_d     = CH_D[64*gidx +: 64];
  assign sel_b     = CH_B[4*gidx +: 4];
  assign xfer      = sel_valid && CH_READY[gidx];
  assign burst_end = xfer && (sel_last || beat_cnt == LAST_CNT);
  // Just-served channel moves to lowest priority.
  assign nxt_ptr   = (gidx == IW'(NUM_CH - 1)) ? '0 : gidx + 1'b1;

  assign GRANT     = grant_q;
  assign BUSY      = (state != ST_IDLE);
  assign USER_TX_D = tx_d;
  assign USER_TX_B = tx_b;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= ST_IDLE;
      grant_q  <= '0;
      gidx     <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
      tx_d     <= '0;
      tx_b     <= '0;
`ifdef SITCPXG_TX_HEADER_EN
      for (int i = 0; i < NUM_CH; i++) seq[i] <= '0;
`endif
    end else begin
      tx_b <= '0;
      if (xfer) begin
        tx_d <= sel_d;
        tx_b <= clamp_bytes(sel_b);
      end

      case (state)
        ST_IDLE: begin
          if (USER_SESSION_ESTABLISHED && pick_any) begin
            grant_q  <= pick_grant;
            gidx     <= pick_idx;
            beat_cnt <= '0;
`ifdef SITCPXG_TX_HEADER_EN
            state    <= ST_HDR;
`else
            state    <= ST_DATA;
`endif
          end
        end

`ifdef SITCPXG_TX_HEADER_EN
        ST_HDR: begin
          if (!USER_SESSION_ESTABLISHED) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            ptr     <= nxt_ptr;
          end else if (!USER_TX_AFULL) begin
            tx_d      <= {HDR_MAGIC, 8'(gidx), 8'h00, seq[gidx]};
            tx_b      <= MAX_BYTES;
            seq[gidx] <= seq[gidx] + 32'd1;
            state     <= ST_DATA;
          end
        end
`endif

        ST_DATA: begin
          if (!USER_SESSION_ESTABLISHED) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            ptr     <= nxt_ptr;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + 16'd1;
            if (burst_end) begin
              state   <= ST_IDLE;
              grant_q <= '0;
              ptr     <= nxt_ptr;
            end
          end
        end

        default: begin
          state   <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sitcpxg_tx_arbiter.sv
`timescale 1ns/100ps
module tb_sitcpxg_tx_arbiter;

  localparam int NCH = 4;
`ifdef SITCPXG_TX_HEADER_EN
  localparam int HDRW = 1;
`else
  localparam int HDRW = 0;
`endif

  logic              CLK = 1'b0;
  logic              RSTn;
  logic [NCH-1:0]    CH_VALID;
  logic [64*NCH-1:0] CH_D;
  logic [4*NCH-1:0]  CH_B;
  logic [NCH-1:0]    CH_LAST;
  logic [NCH-1:0]    CH_READY;
  logic              USER_SESSION_ESTABLISHED;
  logic              USER_TX_AFULL;
  logic [63:0]       USER_TX_D;
  logic [3:0]        USER_TX_B;
  logic [NCH-1:0]    GRANT;
  logic              BUSY;

  sitcpxg_tx_arbiter #(.NUM_CH(NCH), .BURST_WORDS(128)) dut (
    .CLK                      (CLK),
    .RSTn                     (RSTn),
    .CH_VALID                 (CH_VALID),
    .CH_D                     (CH_D),
    .CH_B                     (CH_B),
    .CH_LAST                  (CH_LAST),
    .CH_READY                 (CH_READY),
    .USER_SESSION_ESTABLISHED (USER_SESSION_ESTABLISHED),
    .USER_TX_AFULL            (USER_TX_AFULL),
    .USER_TX_D                (USER_TX_D),
    .USER_TX_B                (USER_TX_B),
    .GRANT                    (GRANT),
    .BUSY                     (BUSY)
  );

  always #3.2 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // source beat stores, one per channel
  logic [63:0] sd [NCH][256];
  logic [3:0]  sb [NCH][256];
  logic        sl [NCH][256];
  int          wr [NCH];
  int          rd [NCH];
  int          acc [NCH];
  int          glog [$];
  logic [63:0] ow [$];
  logic [NCH-1:0] prev_g;
  int          n8;
  int          bsum;
  logic        chk_zero;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input int ch, input logic [3:0] b, input logic last);
    sd[ch][wr[ch]] = {8'hC0 | 8'(ch), 24'h0, 32'(wr[ch])};
    sb[ch][wr[ch]] = b;
    sl[ch][wr[ch]] = last;
    wr[ch]++;
  endtask

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      if (rd[i] < wr[i]) begin
        CH_VALID[i]      = 1'b1;
        CH_D[64*i +: 64] = sd[i][rd[i]];
        CH_B[4*i +: 4]   = sb[i][rd[i]];
        CH_LAST[i]       = sl[i][rd[i]];
      end else begin
        CH_VALID[i]      = 1'b0;
        CH_D[64*i +: 64] = '0;
        CH_B[4*i +: 4]   = '0;
        CH_LAST[i]       = 1'b0;
      end
    end
  endtask

  // One clock: capture handshakes, advance sources, check the output word.
  task automatic tick();
    logic [NCH-1:0] x;
    logic [3:0]     eb;
    x = CH_VALID & CH_READY;
    @(posedge CLK);
    #1;
    if (x == '0) begin
      if (chk_zero) chk("idle_b", {60'h0, USER_TX_B}, 64'h0);
    end
    for (int i = 0; i < NCH; i++) begin
      if (x[i]) begin
        eb = (sb[i][rd[i]] > 4'd8) ? 4'd8 : sb[i][rd[i]];
        chk("out_b", {60'h0, USER_TX_B}, {60'h0, eb});
        chk("out_d", USER_TX_D, sd[i][rd[i]]);
        rd[i]++;
        acc[i]++;
      end
    end
    if (USER_TX_B == 4'd8) n8++;
    bsum += int'(USER_TX_B);
    if (USER_TX_B != 4'd0) ow.push_back(USER_TX_D);
    if (GRANT != '0 && GRANT != prev_g) begin
      for (int i = 0; i < NCH; i++) if (GRANT[i]) glog.push_back(i);
    end
    prev_g = GRANT;
    drive();
    #1;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    USER_SESSION_ESTABLISHED = 1'b0;
    USER_TX_AFULL = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      wr[i] = 0; rd[i] = 0; acc[i] = 0;
    end
    glog.delete();
    ow.delete();
    prev_g = '0;
    n8 = 0;
    bsum = 0;
    drive();
    repeat (2) @(posedge CLK);
    #1;
    RSTn = 1'b1;
    #1;
  endtask

  task automatic run_until(input int ch, input int n, input int bound);
    int k;
    k = 0;
    while (acc[ch] < n && k < bound) begin
      tick();
      k++;
    end
  endtask

  initial begin
    int snap;
    int k;
`ifdef SITCPXG_TX_HEADER_EN
    chk_zero = 1'b0;
`else
    chk_zero = 1'b1;
`endif
    // reset values with requests and session already active
    RSTn = 1'b0;
    USER_SESSION_ESTABLISHED = 1'b1;
    USER_TX_AFULL = 1'b0;
    CH_VALID = '1; CH_D = '1; CH_B = '1; CH_LAST = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", {60'h0, CH_READY}, 64'h0);
    chk("rst_txd", USER_TX_D, 64'h0);
    chk("rst_txb", {60'h0, USER_TX_B}, 64'h0);
    chk("rst_grant", {60'h0, GRANT}, 64'h0);
    chk("rst_busy", {63'h0, BUSY}, 64'h0);

    // single channel, 3 beats of 8 bytes
    do_reset();
    push(0, 4'd8, 1'b0); push(0, 4'd8, 1'b0); push(0, 4'd8, 1'b1);
    USER_SESSION_ESTABLISHED = 1'b1;
    drive(); #1;
    tick();
    repeat (HDRW) tick();
    chk("t1_grant", {60'h0, GRANT}, 64'h1);
    chk("t1_busy", {63'h0, BUSY}, 64'h1);
    chk("t1_ready", {60'h0, CH_READY}, 64'h1);
    repeat (8) tick();
    chk("t1_n8", 64'(n8), 64'(3 + HDRW));
    chk("t1_acc", 64'(acc[0]), 64'd3);
    chk("t1_grant_end", {60'h0, GRANT}, 64'h0);
    chk("t1_busy_end", {63'h0, BUSY}, 64'h0);

    // byte count 0 is forwarded, 12 clamps to 8
    do_reset();
    push(1, 4'd0, 1'b0); push(1, 4'd12, 1'b0); push(1, 4'd5, 1'b1);
    USER_SESSION_ESTABLISHED = 1'b1;
    drive(); #1;
    repeat (8) tick();
    chk("t2_acc", 64'(acc[1]), 64'd3);
    chk("t2_bsum", 64'(bsum), 64'(13 + 8*HDRW));
    chk("t2_grant_end", {60'h0, GRANT}, 64'h0);

    // all channels, two 2-beat bursts each
    do_reset();
    for (int c = 0; c < NCH; c++) begin
      push(c, 4'd8, 1'b0); push(c, 4'd8, 1'b1);
      push(c, 4'd8, 1'b0); push(c, 4'd8, 1'b1);
    end
    USER_SESSION_ESTABLISHED = 1'b1;
    drive(); #1;
    run_until(3, 4, 80);
    chk("t3_glog_n", 64'(glog.size()), 64'd8);
    for (int j = 0; j < 8; j++) begin
      if (j < glog.size()) chk("t3_order", 64'(glog[j]), 64'(j % 4));
    end
    for (int c = 0; c < NCH; c++) chk("t3_acc", 64'(acc[c]), 64'd4);

    // burst length limit: ch2 without CH_LAST, ch3 waiting
    do_reset();
    for (int j = 0; j < 200; j++) push(2, 4'd8, 1'b0);
    push(3, 4'd8, 1'b0); push(3, 4'd8, 1'b1);
    USER_SESSION_ESTABLISHED = 1'b1;
    drive(); #1;
    k = 0;
    while (GRANT != 4'b1000 && k < 300) begin
      tick();
      k++;
    end
    chk("t4_grant3", {60'h0, GRANT}, 64'h8);
    chk("t4_acc2", 64'(acc[2]), 64'd128);
    if (glog.size() > 0) chk("t4_first", 64'(glog[0]), 64'd2);
    run_until(3, 2, 20);
    chk("t4_acc3", 64'(acc[3]), 64'd2);

    // AFULL for 10 cycles mid-burst
    do_reset();
    for (int j = 0; j < 20; j++) push(0, 4'd8, j == 19);
    USER_SESSION_ESTABLISHED = 1'b1;
    drive(); #1;
    repeat (5 + HDRW) tick();
    USER_TX_AFULL = 1'b1;
    #1;
    snap = acc[0];
    for (int j = 0; j < 10; j++) begin
      chk("t5_ready_af", {60'h0, CH_READY}, 64'h0);
      if (j > 0) chk("t5_txb_af", {60'h0, USER_TX_B}, 64'h0);
      tick();
    end
    chk("t5_txb_af_end", {60'h0, USER_TX_B}, 64'h0);
    chk("t5_acc_hold", 64'(acc[0]), 64'(snap));
    USER_TX_AFULL = 1'b0;
    #1;
    chk("t5_ready_resume", {60'h0, CH_READY}, 64'h1);
    run_until(0, 20, 40);
    repeat (2) tick();
    chk("t5_acc", 64'(acc[0]), 64'd20);
    chk("t5_n8", 64'(n8), 64'(20 + HDRW));

    // session loss mid-burst on ch1
    do_reset();
    for (int j = 0; j < 10; j++) push(1, 4'd8, j == 9);
    push(2, 4'd8, 1'b0); push(2, 4'd8, 1'b0); push(2, 4'd8, 1'b1);
    USER_SESSION_ESTABLISHED = 1'b1;
    drive(); #1;
    repeat (3) tick();
    chk("t6_grant1", {60'h0, GRANT}, 64'h2);
    USER_SESSION_ESTABLISHED = 1'b0;
    #1;
    chk("t6_ready_drop", {60'h0, CH_READY}, 64'h0);
    snap = acc[1];
    tick();
    chk("t6_grant_drop", {60'h0, GRANT}, 64'h0);
    chk("t6_busy_drop", {63'h0, BUSY}, 64'h0);
    chk("t6_acc_drop", 64'(acc[1]), 64'(snap));
    USER_SESSION_ESTABLISHED = 1'b1;
    #1;
    tick();
    chk("t6_grant2", {60'h0, GRANT}, 64'h4);

    // asynchronous reset mid-burst
    do_reset();
    for (int j = 0; j < 10; j++) push(0, 4'd8, 1'b0);
    USER_SESSION_ESTABLISHED = 1'b1;
    drive(); #1;
    repeat (4) tick();
    chk("t7_pre_txb", {60'h0, USER_TX_B}, 64'h8);
    #1;
    RSTn = 1'b0;
    #0.5;
    chk("t7_grant", {60'h0, GRANT}, 64'h0);
    chk("t7_busy", {63'h0, BUSY}, 64'h0);
    chk("t7_ready", {60'h0, CH_READY}, 64'h0);
    chk("t7_txb", {60'h0, USER_TX_B}, 64'h0);
    chk("t7_txd", USER_TX_D, 64'h0);

`ifdef SITCPXG_TX_HEADER_EN
    // header word before each burst, sequence counts per channel
    do_reset();
    push(0, 4'd8, 1'b0); push(0, 4'd8, 1'b1);
    push(0, 4'd8, 1'b0); push(0, 4'd8, 1'b1);
    USER_SESSION_ESTABLISHED = 1'b1;
    drive(); #1;
    repeat (20) tick();
    chk("t8_words", 64'(ow.size()), 64'd6);
    if (ow.size() == 6) begin
      chk("t8_hdr0", ow[0], 64'hA55A_0000_0000_0000);
      chk("t8_hdr1", ow[3], 64'hA55A_0000_0000_0001);
      chk("t8_d2", ow[4], 64'hC000_0000_0000_0002);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
